ks_adder_pipe: RTL

Parametrised, pipelined Kogge-Stone adder/subtractor with valid/ready handshakes on both sides and an in-order tag sideband. Generalises the fixed 16-bit combinational Kogge-Stone adder to any operand width. It registers every prefix level so the adder can sit in the datapath at full clock rate. Backpressure stalls the whole pipeline in lockstep.

---
 rtl/ks_adder_pkg.sv | 32 +++
 rtl/ks_prefix_level.sv | 54 +++++
 rtl/ks_adder_pipe.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ks_adder_pkg.sv
// Shared helpers and stage context for the pipelined Kogge-Stone adder.
// Sign-bit context fields exist only when KS_ADDER_PIPE_OVF_EN is defined.
package ks_adder_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  function automatic int ks_levels(input int width);
    return clog2(width);
  endfunction

  // Per-stage context travelling beside the G/P vectors; the tag is kept
  // separate because its width is a module parameter.
  typedef struct packed {
    logic valid;
    logic sub;
    logic cin;
`ifdef KS_ADDER_PIPE_OVF_EN
    logic a_msb;
    logic b_msb;
`endif
  } ks_ctx_t;

  localparam ks_ctx_t KS_CTX_IDLE = '0;

endpackage

// File: rtl/ks_prefix_level.sv
// One registered Kogge-Stone prefix level combining bit i with bit i-DIST.
// Context, tag and half-sum vector pass through unchanged.
module ks_prefix_level
  import ks_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIST  = 1,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  ks_ctx_t          prev_ctx,
  input  logic [TAG_W-1:0] prev_tag,
  input  logic [WIDTH-1:0] prev_g,
  input  logic [WIDTH-1:0] prev_p,
  input  logic [WIDTH-1:0] prev_hs,
  output ks_ctx_t          ctx,
  output logic [TAG_W-1:0] tag,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] hs
);

  logic [WIDTH-1:0] g_next;
  logic [WIDTH-1:0] p_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i >= DIST) begin : g_merge
      assign g_next[i] = prev_g[i] | (prev_p[i] & prev_g[i-DIST]);
      assign p_next[i] = prev_p[i] & prev_p[i-DIST];
    end else begin : g_pass
      assign g_next[i] = prev_g[i];
      assign p_next[i] = prev_p[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctx <= KS_CTX_IDLE;
      tag <= '0;
      g   <= '0;
      p   <= '0;
      hs  <= '0;
    end else if (adv) begin
      ctx <= prev_ctx;
      tag <= prev_tag;
      g   <= g_next;
      p   <= p_next;
      hs  <= prev_hs;
    end
  end

endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready on both sides.
// Define KS_ADDER_PIPE_OVF_EN to add the signed-overflow output out_ovf.
module ks_adder_pipe
  import ks_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic [TAG_W-1:0] out_tag
`ifdef KS_ADDER_PIPE_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int LEVELS = ks_levels(WIDTH);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // The whole pipe advances together whenever the output slot is free or
  // being drained; empty stages are not squeezed out.
  logic adv;
  assign adv      = out_ready || !out_valid;
  assign in_ready = adv || !rst_n;

  ks_ctx_t          ctx_s [0:LEVELS];
  logic [TAG_W-1:0] tag_s [0:LEVELS];
  logic [WIDTH-1:0] g_s   [0:LEVELS];
  logic [WIDTH-1:0] p_s   [0:LEVELS];
  logic [WIDTH-1:0] hs_s  [0:LEVELS];

  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [WIDTH-1:0] p0;
  logic [WIDTH-1:0] g0;

  assign b_eff = in_sub ? ~in_b : in_b;
  assign c0    = in_sub | in_cin;
  assign p0    = in_a ^ b_eff;
  // Carry-in folded into bit 0 generate, acting as the bit -1 generate.
  assign g0    = (in_a & b_eff) | {{(WIDTH-1){1'b0}}, p0[0] & c0};

  ks_ctx_t          s0_ctx;
  logic [TAG_W-1:0] s0_tag;
  logic [WIDTH-1:0] s0_g;
  logic [WIDTH-1:0] s0_p;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_ctx <= KS_CTX_IDLE;
      s0_tag <= '0;
      s0_g   <= '0;
      s0_p   <= '0;
    end else if (adv) begin
      s0_ctx.valid <= in_valid;
      s0_ctx.sub   <= in_sub;
      s0_ctx.cin   <= in_cin;
`ifdef KS_ADDER_PIPE_OVF_EN
      s0_ctx.a_msb <= in_a[WIDTH-1];
      s0_ctx.b_msb <= b_eff[WIDTH-1];
`endif
      s0_tag <= in_tag;
      s0_g   <= g0;
      s0_p   <= p0;
    end
  end

  assign ctx_s[0] = s0_ctx;
  assign tag_s[0] = s0_tag;
  assign g_s[0]   = s0_g;
  assign p_s[0]   = s0_p;
  assign hs_s[0]  = s0_p;

  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    ks_prefix_level #(
      .WIDTH (WIDTH),
      .DIST  (1 << k),
      .TAG_W (TAG_W)
    ) u_level (
      .clk      (clk),
      .rst_n    (rst_n),
      .adv      (adv),
      .prev_ctx (ctx_s[k]),
      .prev_tag (tag_s[k]),
      .prev_g   (g_s[k]),
      .prev_p   (p_s[k]),
      .prev_hs  (hs_s[k]),
      .ctx      (ctx_s[k+1]),
      .tag      (tag_s[k+1]),
      .g        (g_s[k+1]),
      .p        (p_s[k+1]),
      .hs       (hs_s[k+1])
    );
  end

  // Carry into bit i is the group generate of bits i-1..0; bit 0 takes C0.
  ks_ctx_t          last_ctx;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_next;

  assign last_ctx = ctx_s[LEVELS];
  assign carry    = {g_s[LEVELS][WIDTH-2:0], last_ctx.sub | last_ctx.cin};
  assign sum_next = hs_s[LEVELS] ^ carry;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_tag   <= '0;
    end else if (adv) begin
      out_valid <= last_ctx.valid;
      out_sum   <= sum_next;
      out_cout  <= g_s[LEVELS][WIDTH-1];
      out_tag   <= tag_s[LEVELS];
    end
  end

`ifdef KS_ADDER_PIPE_OVF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_ovf <= 1'b0;
    end else if (adv) begin
      out_ovf <= (last_ctx.a_msb == last_ctx.b_msb) &&
                 (sum_next[WIDTH-1] != last_ctx.a_msb);
    end
  end
`endif

endmodule
